// File: rtl/delay_ser_pkg.sv
// rtl/delay_ser_pkg.sv - shared types and helpers for the delay-stage state serializer
package delay_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int idx_w(input int vector);
        return (vector > 1) ? $clog2(vector) : 1;
    endfunction

endpackage

// File: rtl/delay_state_serializer_if.sv
// rtl/delay_state_serializer_if.sv - per-lane output beat stream of the state serializer
interface delay_state_serializer_if #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 4
);
    import delay_ser_pkg::*;

    localparam int IW = idx_w(VECTOR);

    logic                 out_valid;
    logic                 out_ready;
    logic [REG_WIDTH-1:0] out_a;
    logic [REG_WIDTH-1:0] out_b;
    logic [IW-1:0]        out_idx;
    logic                 out_last;

    modport master (
        output out_valid,
        output out_a,
        output out_b,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_a,
        input  out_b,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/delay_ser_bank.sv
// rtl/delay_ser_bank.sv - snapshot bank for the a/b state vectors with indexed read
module delay_ser_bank
    import delay_ser_pkg::*;
#(
    parameter  int REG_WIDTH = 16,
    parameter  int VECTOR    = 4,
    localparam int IW        = idx_w(VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [REG_WIDTH-1:0] a_in [VECTOR-1:0],
    input  logic [REG_WIDTH-1:0] b_in [VECTOR-1:0],
    input  logic [IW-1:0]        idx,
    output logic [REG_WIDTH-1:0] rd_a,
    output logic [REG_WIDTH-1:0] rd_b
);

    logic [REG_WIDTH-1:0] a_q [VECTOR-1:0];
    logic [REG_WIDTH-1:0] a_d [VECTOR-1:0];
    logic [REG_WIDTH-1:0] b_q [VECTOR-1:0];
    logic [REG_WIDTH-1:0] b_d [VECTOR-1:0];

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
            a_d = a_in;
            b_d = b_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VECTOR; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign rd_a = a_q[idx];
    assign rd_b = b_q[idx];

endmodule

// File: rtl/delay_state_serializer.sv
// rtl/delay_state_serializer.sv - snapshot a/b state vectors, drain one lane per beat (DELAY_SER_DROP_EN adds cap_drop)
module delay_state_serializer
    import delay_ser_pkg::*;
#(
    parameter  int REG_WIDTH = 16,
    parameter  int VECTOR    = 4,
    localparam int IW        = idx_w(VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_valid,
    output logic                 cap_ready,
`ifdef DELAY_SER_DROP_EN
    output logic                 cap_drop,
`endif
    input  logic [REG_WIDTH-1:0] a_in [VECTOR-1:0],
    input  logic [REG_WIDTH-1:0] b_in [VECTOR-1:0],
    delay_state_serializer_if.master out_if,
    output logic                 busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR - 1);

    ser_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          out_valid;
    logic          out_last;
    logic          xfer;
    logic          load;

    assign out_valid = (state_q == SEND);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign xfer      = out_valid && out_if.out_ready;
    // Accepting on the final beat lets back-to-back snapshots stream without a bubble.
    assign cap_ready = (state_q == IDLE) || (xfer && out_last);
    assign load      = cap_valid && cap_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (cap_valid) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        idx_d   = '0;
                        state_d = cap_valid ? SEND : IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

`ifdef DELAY_SER_DROP_EN
    logic cap_drop_q, cap_drop_d;

    always_comb begin
        cap_drop_d = cap_valid && !cap_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_drop_q <= 1'b0;
        end else begin
            cap_drop_q <= cap_drop_d;
        end
    end

    assign cap_drop = cap_drop_q;
`endif

    delay_ser_bank #(
        .REG_WIDTH (REG_WIDTH),
        .VECTOR    (VECTOR)
    ) u_bank (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .a_in (a_in),
        .b_in (b_in),
        .idx  (idx_q),
        .rd_a (out_if.out_a),
        .rd_b (out_if.out_b)
    );

    assign out_if.out_valid = out_valid;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_last  = out_last;
    assign busy             = out_valid;

endmodule
